// File: rtl/sdram_slot_sched_if.sv
// Client-side request/response bundle for the SDRAM slot scheduler.
// A request transfers on the cycle where valid && ready are both high; fields are held while valid && !ready.
interface sdram_slot_sched_if #(parameter int ADDR_W = 25);
  logic              a_valid;
  logic              a_ready;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_wdata;
  logic              a_rsp_valid;
  logic [7:0]        a_rsp_rdata;
  logic              b_valid;
  logic              b_ready;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_wdata;
  logic              b_rsp_valid;
  logic [7:0]        b_rsp_rdata;

  modport master (
    output a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata,
    input  a_ready, a_rsp_valid, a_rsp_rdata, b_ready, b_rsp_valid, b_rsp_rdata
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata, b_valid, b_we, b_addr, b_wdata,
    output a_ready, a_rsp_valid, a_rsp_rdata, b_ready, b_rsp_valid, b_rsp_rdata
  );
endinterface

// File: rtl/sdram_slot_sched.sv
// Slot scheduler in front of the dual-port byte SDRAM controller: clkref/init generation,
// A/B slot loading on 16-cycle phase boundaries, and forced idle slots for auto-refresh.
module sdram_slot_sched #(
  parameter int ADDR_W         = 25,
  parameter int INIT_HOLD      = 16,
  parameter int INIT_WAIT      = 320,
  parameter int MAX_BUSY_SLOTS = 16
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  sdram_slot_sched_if.slave                     cl,
  output logic                                  clkref,
  output logic                                  sd_init,
  output logic                                  oeA,
  output logic                                  weA,
  output logic [ADDR_W-1:0]                     addrA,
  output logic [7:0]                            dinA,
  input  logic [7:0]                            doutA,
  output logic                                  oeB,
  output logic                                  weB,
  output logic [ADDR_W-1:0]                     addrB,
  output logic [7:0]                            dinB,
  input  logic [7:0]                            doutB,
  output logic [3:0]                            dbg_ph,
  output logic [$clog2(MAX_BUSY_SLOTS+1)-1:0]   dbg_busy_cnt
);
  localparam int IW = $clog2(INIT_WAIT + 1);
  localparam int BW = $clog2(MAX_BUSY_SLOTS + 1);
  localparam logic [IW-1:0] INIT_WAIT_C = IW'(INIT_WAIT);
  localparam logic [IW-1:0] INIT_HOLD_C = IW'(INIT_HOLD);
  localparam logic [BW-1:0] MAX_BUSY_C  = BW'(MAX_BUSY_SLOTS);

  logic [3:0]    ph;
  logic [IW-1:0] init_cnt;
  logic [BW-1:0] busy_cnt;
  logic          init_done;
  logic          force_idle;
  logic          a_bnd, b_bnd;
  logic          a_load, b_load;
  logic          a_act, b_act;

  always_ff @(posedge clk) begin
    if (!resetn) ph <= 4'hF;
    else         ph <= ph + 4'd1;
  end

  // clkref comes straight from a flop bit so the controller sees a glitch-free reference.
  assign clkref = ~ph[3];

  always_ff @(posedge clk) begin
    if (!resetn)                    init_cnt <= '0;
    else if (init_cnt != INIT_WAIT_C) init_cnt <= init_cnt + IW'(1);
  end

  assign sd_init    = (init_cnt < INIT_HOLD_C);
  assign init_done  = (init_cnt == INIT_WAIT_C);
  assign force_idle = (busy_cnt == MAX_BUSY_C);

  assign a_bnd  = (ph == 4'd15);
  assign b_bnd  = (ph == 4'd7);
  assign a_load = a_bnd && init_done && !force_idle && cl.a_valid;
  assign b_load = b_bnd && init_done && !force_idle && cl.b_valid;

  assign cl.a_ready = a_load;
  assign cl.b_ready = b_load;

  // Every boundary either extends the busy run or, when nothing is loaded, lets the controller refresh.
  always_ff @(posedge clk) begin
    if (!resetn)              busy_cnt <= '0;
    else if (a_bnd || b_bnd)  busy_cnt <= (a_load || b_load) ? busy_cnt + BW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      oeA <= 1'b0; weA <= 1'b0; addrA <= '0; dinA <= '0; a_act <= 1'b0;
      cl.a_rsp_valid <= 1'b0; cl.a_rsp_rdata <= '0;
    end else begin
      if (a_load) begin
        oeA <= ~cl.a_we; weA <= cl.a_we; addrA <= cl.a_addr; dinA <= cl.a_wdata; a_act <= 1'b1;
      end else if (a_bnd) begin
        oeA <= 1'b0; weA <= 1'b0; a_act <= 1'b0;
      end
      // A slot completes at the edge ending ph 7; read data is taken from the controller then.
      cl.a_rsp_valid <= b_bnd && a_act;
      if (b_bnd && a_act && oeA) cl.a_rsp_rdata <= doutA;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      oeB <= 1'b0; weB <= 1'b0; addrB <= '0; dinB <= '0; b_act <= 1'b0;
      cl.b_rsp_valid <= 1'b0; cl.b_rsp_rdata <= '0;
    end else begin
      if (b_load) begin
        oeB <= ~cl.b_we; weB <= cl.b_we; addrB <= cl.b_addr; dinB <= cl.b_wdata; b_act <= 1'b1;
      end else if (b_bnd) begin
        oeB <= 1'b0; weB <= 1'b0; b_act <= 1'b0;
      end
      cl.b_rsp_valid <= a_bnd && b_act;
      if (a_bnd && b_act && oeB) cl.b_rsp_rdata <= doutB;
    end
  end

  assign dbg_ph       = ph;
  assign dbg_busy_cnt = busy_cnt;
endmodule

// File: tb/tb_sdram_slot_sched.sv
// Randomized bench for sdram_slot_sched: a time-based reference model predicts phase, init,
// slot contents and responses; a negedge monitor compares and pops expected responses.
module tb_sdram_slot_sched;
  localparam int ADDR_W    = 25;
  localparam int INIT_HOLD = 16;
  localparam int INIT_WAIT = 320;
  localparam int MAXB      = 16;
  localparam int W         = 40;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;

  sdram_slot_sched_if #(.ADDR_W(ADDR_W)) bus();

  logic              clkref, sd_init, oeA, weA, oeB, weB;
  logic [ADDR_W-1:0] addrA, addrB;
  logic [7:0]        dinA, dinB, doutA, doutB;
  logic [3:0]        dbg_ph;
  logic [4:0]        dbg_busy_cnt;

  sdram_slot_sched #(.ADDR_W(ADDR_W), .INIT_HOLD(INIT_HOLD), .INIT_WAIT(INIT_WAIT),
                     .MAX_BUSY_SLOTS(MAXB)) dut (
    .clk(clk), .resetn(resetn), .cl(bus),
    .clkref(clkref), .sd_init(sd_init),
    .oeA(oeA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA),
    .oeB(oeB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB),
    .dbg_ph(dbg_ph), .dbg_busy_cnt(dbg_busy_cnt)
  );

  // Reference model state: t counts clock edges since reset release.
  int                t;
  int                run;
  logic              ma_oe, ma_we, mb_oe, mb_we;
  logic [ADDR_W-1:0] ma_addr, mb_addr;
  logic [7:0]        ma_din, mb_din, last_a, last_b;
  logic [W-1:0]      exp_qa[$];
  logic [W-1:0]      exp_qb[$];
  int                checks = 0;
  int                errors = 0;

  function automatic logic [7:0] ctl_data(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'd0, a[24]} ^ 8'h78;
  endfunction

  function automatic int cur_ph();
    return (15 + t) % 16;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Model update on each active edge, from the request rules only.
  initial begin
    t = 0; run = 0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        t = 0; run = 0;
        ma_oe = 0; ma_we = 0; ma_addr = '0; ma_din = '0; last_a = '0;
        mb_oe = 0; mb_we = 0; mb_addr = '0; mb_din = '0; last_b = '0;
        exp_qa.delete(); exp_qb.delete();
      end else begin
        if (cur_ph() == 15) begin
          if (t >= INIT_WAIT && run != MAXB && bus.a_valid) begin
            run++;
            ma_oe = !bus.a_we; ma_we = bus.a_we; ma_addr = bus.a_addr; ma_din = bus.a_wdata;
            if (!bus.a_we) last_a = ctl_data(bus.a_addr);
            exp_qa.push_back({32'(t + 9), last_a});
          end else begin
            run = 0; ma_oe = 0; ma_we = 0;
          end
        end else if (cur_ph() == 7) begin
          if (t >= INIT_WAIT && run != MAXB && bus.b_valid) begin
            run++;
            mb_oe = !bus.b_we; mb_we = bus.b_we; mb_addr = bus.b_addr; mb_din = bus.b_wdata;
            if (!bus.b_we) last_b = ctl_data(bus.b_addr);
            exp_qb.push_back({32'(t + 9), last_b});
          end else begin
            run = 0; mb_oe = 0; mb_we = 0;
          end
        end
        t++;
      end
    end
  end

  // Monitor and scoreboard, plus controller model driving doutA/doutB late in each slot.
  initial begin
    logic [W-1:0] e;
    logic         exp_v;
    int           p;
    forever begin
      @(negedge clk);
      p = cur_ph();
      if (chk_en) begin
        check("ph", dbg_ph, p);
        check("clkref", clkref, p < 8);
        check("sd_init", sd_init, t < INIT_HOLD);
        check("busy_cnt", dbg_busy_cnt, run);
        check("a_ready", bus.a_ready, p == 15 && t >= INIT_WAIT && run != MAXB && bus.a_valid);
        check("b_ready", bus.b_ready, p == 7 && t >= INIT_WAIT && run != MAXB && bus.b_valid);
        check("oeA", oeA, ma_oe);
        check("weA", weA, ma_we);
        check("addrA", addrA, ma_addr);
        check("dinA", dinA, ma_din);
        check("oeB", oeB, mb_oe);
        check("weB", weB, mb_we);
        check("addrB", addrB, mb_addr);
        check("dinB", dinB, mb_din);
        exp_v = (exp_qa.size() != 0) && (exp_qa[0][39:8] == 32'(t));
        check("a_rsp_valid", bus.a_rsp_valid, exp_v);
        if (exp_v) begin
          e = exp_qa.pop_front();
          check("a_rsp_rdata", bus.a_rsp_rdata, e[7:0]);
        end
        exp_v = (exp_qb.size() != 0) && (exp_qb[0][39:8] == 32'(t));
        check("b_rsp_valid", bus.b_rsp_valid, exp_v);
        if (exp_v) begin
          e = exp_qb.pop_front();
          check("b_rsp_rdata", bus.b_rsp_rdata, e[7:0]);
        end
      end
      doutA = (oeA && p >= 4 && p <= 7) ? ctl_data(addrA) : 8'($urandom);
      doutB = (oeB && p >= 12) ? ctl_data(addrB) : 8'($urandom);
    end
  end

  task automatic drive_a(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] d);
    bit got = 0;
    bus.a_valid = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (bus.a_ready) got = 1;
    end
    @(posedge clk); #1;
    bus.a_valid = 0;
    check("a_accept", got, 1);
  endtask

  task automatic drive_b(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] d);
    bit got = 0;
    bus.b_valid = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (bus.b_ready) got = 1;
    end
    @(posedge clk); #1;
    bus.b_valid = 0;
    check("b_accept", got, 1);
  endtask

  task automatic wait_ph(input int target);
    for (int n = 0; n < 40 && cur_ph() != target; n++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.a_valid = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_valid = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    doutA = '0; doutB = '0;
    idle(3);
    chk_en = 1;
    idle(2);
    resetn = 1;

    // Request held from well before init completes: must first be taken at t == INIT_WAIT.
    idle(200);
    drive_a(1'b0, 25'h000123, 8'h00);
    drive_b(1'b1, 25'h1FFFFFF, 8'hC3);
    drive_a(1'b1, 25'($urandom), 8'($urandom));
    drive_b(1'b0, 25'($urandom), 8'($urandom));
    drive_a(1'b0, 25'($urandom), 8'($urandom));
    idle(20);

    // Both clients continuously valid: exercises the forced idle slot twice.
    fork
      begin
        for (int i = 0; i < 20; i++)
          drive_a(1'($urandom_range(0, 1)), 25'($urandom), 8'($urandom));
      end
      begin
        for (int i = 0; i < 20; i++)
          drive_b(1'($urandom_range(0, 1)), 25'($urandom), 8'($urandom));
      end
    join
    idle(20);

    // Valid raised at ph0 and dropped at ph10 never reaches a boundary.
    wait_ph(0);
    bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 25'($urandom); bus.a_wdata = 8'($urandom);
    wait_ph(10);
    bus.a_valid = 0;
    idle(20);

    // Reset in the middle of an A read: response dropped, init rerun.
    drive_a(1'b0, 25'($urandom), 8'($urandom));
    wait_ph(3);
    resetn = 0;
    idle(1);
    resetn = 1;

    for (int i = 0; i < 4; i++) begin
      drive_b(1'($urandom_range(0, 1)), 25'($urandom), 8'($urandom));
      drive_a(1'($urandom_range(0, 1)), 25'($urandom), 8'($urandom));
    end
    idle(40);

    check("a_queue_drained", exp_qa.size(), 0);
    check("b_queue_drained", exp_qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_slot_sched.md
Name: sdram_slot_sched

Overview:
- Upstream request scheduler for the dual-port byte SDRAM controller.
- Generates that controller's `clkref` phase reference and its `init` pulse.
- Accepts valid/ready byte requests from two clients: A (CPU, serviced while `clkref` is high) and B (PPU/video, serviced while `clkref` is low). It drives the controller's A/B request pins stable for a whole slot and returns read data and write completion as one-cycle responses.
- Inserts forced idle slots so the controller's idle-slot auto-refresh is guaranteed.

Parameters:
- ADDR_W, 25, byte address width on both client and controller sides.
- INIT_HOLD, 16, clk cycles that `sd_init` is held high after reset.
- INIT_WAIT, 320, clk cycles after reset before any request is accepted (covers the controller's 31×8-cycle init sequence).
- MAX_BUSY_SLOTS, 16, consecutive busy slots (A and B combined) before one idle slot is forced.

Ports:
- clk  in  1  SDRAM-domain clock, same as the controller's clk.
- resetn  in  1  synchronous, active-low reset.
- a_valid  in  1  client A request valid.
- a_ready  out  1  client A request accepted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  byte address.
- a_wdata  in  8  write byte.
- a_rsp_valid  out  1  one-cycle pulse: access finished.
- a_rsp_rdata  out  8  read byte, valid with a_rsp_valid on reads.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rsp_rdata: same as the A ports, for client B.
- clkref  out  1  phase reference to the controller.
- sd_init  out  1  controller init request.
- oeA, weA  out  1 each  controller port A strobes.
- addrA  out  ADDR_W  controller port A address.
- dinA  out  8  controller port A write byte.
- doutA  in  8  controller port A read byte.
- oeB, weB, addrB, dinB, doutB: same as the A signals, for controller port B.

Behaviour:
- Phase counter `ph[3:0]`:
  - Reset value 15; increments mod 16 each clk once out of reset.
  - `clkref = ~ph[3]`, decoded from a single flop bit, so it is glitch-free.
  - `clkref` is high for ph 0..7 (A slot) and low for ph 8..15 (B slot).
- Init:
  - Counter `init_cnt` resets to 0 and saturates at INIT_WAIT.
  - `sd_init = 1` while `init_cnt < INIT_HOLD`.
  - `init_done = (init_cnt == INIT_WAIT)`.
  - `a_ready` and `b_ready` are 0 until `init_done`.
- Slot load, port A:
  - Load condition: ph==15 && init_done && !force_idle && a_valid.
  - `a_ready` is combinational and equals the load condition.
  - On a load edge: oeA <= ~a_we; weA <= a_we; addrA <= a_addr; dinA <= a_wdata; a_act <= 1.
  - On a ph==15 edge without a load: oeA, weA and a_act <= 0. addrA and dinA hold their values.
  - Outputs are therefore stable for ph 0..15.
- Slot load, port B: identical, evaluated at ph==7, so B outputs are stable for ph 8..7.
- At most one acceptance per port per 16 cycles. A client holding valid waits for its next slot boundary.
- Responses:
  - Port A: at the edge ending ph==7, if a_act then a_rsp_valid <= 1 and a_rsp_rdata <= doutA (on reads only; it holds on writes).
  - a_rsp_valid is high for exactly ph==8. Accept-to-response latency is 9 cycles.
  - Port B: same rule at the edge ending ph==15; b_rsp_valid is high for ph==0.
- Refresh guard:
  - `busy_cnt` is evaluated at every slot boundary (ph==7 and ph==15).
  - If the slot being loaded is busy: `busy_cnt++`.
  - If it is idle: `busy_cnt <= 0`.
  - `force_idle = (busy_cnt == MAX_BUSY_SLOTS)`. A forced slot loads nothing (ready stays 0) and clears busy_cnt.
- Reset values:
  - All outputs are 0 except `sd_init` = 1.
  - `ph` = 15, `busy_cnt` = 0, `a_act` and `b_act` = 0.
- Reset mid-operation: in-flight accesses are dropped with no response pulse. The full init sequence is rerun.
- Simultaneous valid on A and B: there is no conflict, since the ports are served in disjoint slots.
- A valid that drops before its boundary is ignored. Clients must hold all request fields while valid && !ready.

Test Plan:
- Reset, then idle for 400 cycles:
  - sd_init is high for cycles 0..15 after reset release.
  - clkref has period 16, high for 8 cycles.
  - No ready asserts before cycle 320.
- A read of 0x000123 after init, with the controller model returning doutA=0x5A:
  - a_ready is high at ph15.
  - oeA=1 and addrA=0x000123 for 16 cycles.
  - a_rsp_valid pulses at ph8 with rdata 0x5A.
- B write of 0x1FFFFFF with data 0xC3:
  - b_ready is high at ph7.
  - weB=1, dinB=0xC3, oeB=0.
  - b_rsp_valid pulses at ph0; b_rsp_rdata is unchanged.
- A and B both continuously valid:
  - Accepts alternate B, A, B, ….
  - After 16 busy slots the next slot has no ready and no strobes.
  - busy_cnt then restarts and the next 16 slots are busy again.
- resetn pulsed low at ph3 of an active A read:
  - No a_rsp_valid.
  - All strobes are 0 and ph is 15 on the cycle after reset.
  - sd_init is re-asserted.
- a_valid raised at ph0 and dropped at ph10: never accepted, and weA/oeA stay 0.
